// File: rtl/gctrl.sv
// Shared sequencer definitions: state and write-back-select encodings,
// instruction class flags and the word-alignment helper.
package gctrl;

    localparam logic [2:0] ST_BOOT   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    // addi x0,x0,0: the instruction register holds a harmless NOP out of reset.
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic is_op;
        logic is_op_imm;
        logic is_lui;
        logic is_auipc;
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_jal;
        logic is_jalr;
        logic is_system;
        logic is_illegal;
    } insn_class_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/gopcode.sv
// RV32I major opcode constants (instr[6:0]) shared across the core.
package gopcode;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

endpackage

// File: rtl/dec.sv
// Instruction decoder: classifies the opcode and extracts rd and every
// immediate format; the sequencer picks the immediate it needs.
module dec
    import gopcode::*;
    import gctrl::*;
(
    input  logic [31:0]                   insn,
    output logic [$bits(insn_class_t)-1:0] cls,
    output logic [4:0]                    rd,
    output logic [31:0]                   imm_i,
    output logic [31:0]                   imm_s,
    output logic [31:0]                   imm_b,
    output logic [31:0]                   imm_u,
    output logic [31:0]                   imm_j
);

    insn_class_t cls_next;

    always_comb begin
        cls_next = '0;
        case (insn[6:0])
            OPC_OP:     cls_next.is_op      = 1'b1;
            OPC_OP_IMM: cls_next.is_op_imm  = 1'b1;
            OPC_LUI:    cls_next.is_lui     = 1'b1;
            OPC_AUIPC:  cls_next.is_auipc   = 1'b1;
            OPC_LOAD:   cls_next.is_load    = 1'b1;
            OPC_STORE:  cls_next.is_store   = 1'b1;
            OPC_BRANCH: cls_next.is_branch  = 1'b1;
            OPC_JAL:    cls_next.is_jal     = 1'b1;
            OPC_JALR:   cls_next.is_jalr    = 1'b1;
            OPC_SYSTEM: cls_next.is_system  = 1'b1;
            default:    cls_next.is_illegal = 1'b1;
        endcase
    end

    assign cls   = cls_next;
    assign rd    = insn[11:7];
    assign imm_i = {{20{insn[31]}}, insn[31:20]};
    assign imm_s = {{20{insn[31]}}, insn[31:25], insn[11:7]};
    assign imm_b = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    assign imm_u = {insn[31:12], 12'h000};
    assign imm_j = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

endmodule

// File: rtl/ctrl.sv
// Multi-cycle RV32I sequencer: one instruction in flight, FETCH..WB.
// Define CTRL_TRAP_EN to send illegal opcodes and misaligned targets to a sticky TRAP.
module ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic [31:0] alu_res,
    input  logic        br_take,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic [31:0] imm,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  wb_sel,
    output logic        rf_we,
    output logic        retire,
    output logic        trap
);
    import gctrl::*;

`ifdef CTRL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    logic [2:0]  state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] ir_reg, ir_next;
    logic [31:0] target_reg, target_next;

    logic [$bits(insn_class_t)-1:0] cls_bits;
    insn_class_t cls;
    logic [4:0]  rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    dec u_dec (
        .insn  (ir_reg),
        .cls   (cls_bits),
        .rd    (rd),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_b (imm_b),
        .imm_u (imm_u),
        .imm_j (imm_j)
    );

    assign cls = insn_class_t'(cls_bits);

    logic [31:0] pc_plus4, br_target, jmp_target, flow_target;
    logic        flow_misaligned, is_jump, in_select;

    assign pc_plus4    = pc_reg + 32'd4;
    assign br_target   = br_take ? pc_reg + imm_b : pc_plus4;
    assign jmp_target  = cls.is_jalr ? (alu_res & 32'hFFFF_FFFE) : pc_reg + imm_j;
    assign flow_target = cls.is_branch ? br_target : jmp_target;
    assign flow_misaligned = |flow_target[1:0];
    assign is_jump     = cls.is_jal || cls.is_jalr;

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        ir_next     = ir_reg;
        target_next = target_reg;
        case (state_reg)
            ST_BOOT:   state_next = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_next    = imem_rdata;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: state_next = ST_EXEC;
            ST_EXEC: begin
                if (cls.is_load || cls.is_store) begin
                    state_next = ST_MEM;
                end else if (cls.is_branch || is_jump) begin
                    if (TRAP_EN && flow_misaligned) begin
                        state_next = ST_TRAP;
                    end else if (cls.is_branch) begin
                        pc_next    = align_word(flow_target);
                        state_next = ST_FETCH;
                    end else begin
                        // Jump target is latched here; pc only moves once WB writes the link.
                        target_next = align_word(flow_target);
                        state_next  = ST_WB;
                    end
                end else if (cls.is_op || cls.is_op_imm || cls.is_lui || cls.is_auipc) begin
                    state_next = ST_WB;
                end else if (TRAP_EN && cls.is_illegal) begin
                    state_next = ST_TRAP;
                end else begin
                    pc_next    = pc_plus4;
                    state_next = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (cls.is_store) begin
                        pc_next    = pc_plus4;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_WB;
                    end
                end
            end
            ST_WB: begin
                pc_next    = is_jump ? target_reg : pc_plus4;
                state_next = ST_FETCH;
            end
            ST_TRAP:   state_next = ST_TRAP;
            default:   state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_BOOT;
            pc_reg     <= RESET_PC;
            ir_reg     <= NOP_INSN;
            target_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            ir_reg     <= ir_next;
            target_reg <= target_next;
        end
    end

    always_comb begin
        imm = '0;
        if (cls.is_op_imm || cls.is_load || cls.is_jalr || cls.is_system) imm = imm_i;
        else if (cls.is_store)                 imm = imm_s;
        else if (cls.is_branch)                imm = imm_b;
        else if (cls.is_lui || cls.is_auipc)   imm = imm_u;
        else if (cls.is_jal)                   imm = imm_j;
    end

    assign in_select = state_reg inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB};

    always_comb begin
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        wb_sel    = WB_ALU;
        if (in_select) begin
            alu_a_sel = cls.is_auipc || cls.is_jal;
            alu_b_sel = cls.is_op_imm || cls.is_lui || cls.is_auipc || cls.is_load
                     || cls.is_store || is_jump;
            if (cls.is_load)     wb_sel = WB_MEM;
            else if (is_jump)    wb_sel = WB_PC4;
            else if (cls.is_lui) wb_sel = WB_IMM;
        end
    end

    assign imem_req  = state_reg == ST_FETCH;
    assign imem_addr = pc_reg;
    assign dmem_req  = state_reg == ST_MEM;
    assign dmem_we   = dmem_req && cls.is_store;
    assign rf_we     = (state_reg == ST_WB) && (rd != 5'd0);
    // Every completion path is exactly a return to FETCH from EXEC, MEM or WB.
    assign retire    = (state_next == ST_FETCH) && (state_reg inside {ST_EXEC, ST_MEM, ST_WB});
    assign pc        = pc_reg;
    assign ir        = ir_reg;

`ifdef CTRL_TRAP_EN
    assign trap = state_reg == ST_TRAP;
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl.sv
// Self-checking bench for ctrl: directed test-plan cases then randomized
// instructions, each checked cycle by cycle against a schedule model.
module tb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [31:0] alu_res = '0;
    logic        br_take = 1'b0;
    logic [31:0] pc, ir, imm;
    logic        alu_a_sel, alu_b_sel, rf_we, retire, trap;
    logic [1:0]  wb_sel;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc = 32'h0;

    ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .alu_res(alu_res), .br_take(br_take),
        .pc(pc), .ir(ir), .imm(imm),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .wb_sel(wb_sel),
        .rf_we(rf_we), .retire(retire), .trap(trap)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk32({tag, "_pc"}, pc, 32'h0);
        chk32({tag, "_imem_addr"}, imem_addr, 32'h0);
        chk32({tag, "_ir"}, ir, 32'h0000_0013);
        chk32({tag, "_imm"}, imm, 32'h0);
        chk1({tag, "_imem_req"}, imem_req, 1'b0);
        chk1({tag, "_dmem_req"}, dmem_req, 1'b0);
        chk1({tag, "_dmem_we"}, dmem_we, 1'b0);
        chk1({tag, "_rf_we"}, rf_we, 1'b0);
        chk1({tag, "_retire"}, retire, 1'b0);
        chk1({tag, "_trap"}, trap, 1'b0);
        chk1({tag, "_alu_a_sel"}, alu_a_sel, 1'b0);
        chk1({tag, "_alu_b_sel"}, alu_b_sel, 1'b0);
        chk32({tag, "_wb_sel"}, {30'd0, wb_sel}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_idle("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_idle("boot");
        m_pc = 32'h0;
    endtask

    // Pins the model's pc to a hand-computed value, then the DUT pc one edge later.
    task automatic pc_lit(input string name, input logic [31:0] exp);
        chk32({name, "_model"}, m_pc, exp);
        @(posedge clk);
        #1;
        chk32(name, pc, exp);
    endtask

    // Runs one instruction: iw/dw are ack wait cycles; abort_cyc >= 0 asserts reset in that cycle.
    task automatic run_instr(input logic [31:0] word, input int iw, input int dw, input logic take,
                             input logic [31:0] alu, input int abort_cyc, output int got_cycles);
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, e_imm, tgt, e_next;
        logic        e_a, e_b;
        logic [1:0]  e_wb;
        bit          care_a, care_b, care_wb, care_imm, is_mem, is_st, wr, bad, will_trap;
        bit          e_ireq, e_dreq, e_ret;
        int          len, ms;

        imm_i = {{20{word[31]}}, word[31:20]};
        imm_s = {{20{word[31]}}, word[31:25], word[11:7]};
        imm_b = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
        imm_u = {word[31:12], 12'h000};
        imm_j = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};

        care_a = 1; care_b = 1; care_wb = 1; care_imm = 1;
        is_mem = 0; is_st = 0; wr = 0; bad = 0;
        e_a = 0; e_b = 0; e_wb = 2'd0; e_imm = imm_i;
        e_next = m_pc + 32'd4;
        tgt = e_next;
        len = iw + 4;
        case (word[6:0])
            7'h33: begin care_imm = 0; wr = 1; end
            7'h13: begin e_b = 1; wr = 1; end
            7'h37: begin care_a = 0; care_b = 0; e_wb = 2'd3; e_imm = imm_u; wr = 1; end
            7'h17: begin e_a = 1; e_b = 1; e_imm = imm_u; wr = 1; end
            7'h03: begin e_b = 1; e_wb = 2'd1; is_mem = 1; wr = 1; len = iw + 5 + dw; end
            7'h23: begin e_b = 1; care_wb = 0; e_imm = imm_s; is_mem = 1; is_st = 1; len = iw + 4 + dw; end
            7'h63: begin
                care_a = 0; care_b = 0; care_wb = 0; e_imm = imm_b; len = iw + 3;
                tgt = take ? m_pc + imm_b : m_pc + 32'd4;
            end
            7'h6F: begin care_a = 0; care_b = 0; e_wb = 2'd2; e_imm = imm_j; wr = 1; tgt = m_pc + imm_j; end
            7'h67: begin e_b = 1; e_wb = 2'd2; wr = 1; tgt = alu & 32'hFFFF_FFFE; end
            7'h73: begin care_a = 0; care_b = 0; care_wb = 0; care_imm = 0; len = iw + 3; end
            default: begin care_a = 0; care_b = 0; care_wb = 0; care_imm = 0; len = iw + 3; bad = 1; end
        endcase
        if (word[6:0] inside {7'h63, 7'h6F, 7'h67}) begin
            bad = tgt[1:0] != 2'b00;
            e_next = {tgt[31:2], 2'b00};
        end
`ifdef CTRL_TRAP_EN
        will_trap = bad;
        if (will_trap) len = iw + 3;
`else
        will_trap = 0;
`endif
        ms = iw + 3;
        got_cycles = -1;

        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            imem_ack   = (c == iw) ? 1'b1 : ((c > iw) ? 1'($urandom_range(0, 1)) : 1'b0);
            imem_rdata = (c == iw) ? word : $urandom;
            if (is_mem && c >= ms && c <= ms + dw) dmem_ack = (c == ms + dw);
            else                                   dmem_ack = 1'($urandom_range(0, 1));
            br_take = take;
            alu_res = alu;
            if (c == abort_cyc) begin
                rst_n = 1'b0;
                imem_ack = 1'b0;
                dmem_ack = 1'b0;
                #1;
                chk1("abort_dmem_req", dmem_req, 1'b0);
                chk1("abort_imem_req", imem_req, 1'b0);
                chk1("abort_retire", retire, 1'b0);
                $display("instr pc=%h word=%h aborted by reset in cycle %0d", m_pc, word, c);
                return;
            end
            #1;
            e_ireq = c <= iw;
            e_dreq = is_mem && c >= ms && c <= ms + dw;
            e_ret  = (c == len - 1) && !will_trap;
            chk1("imem_req", imem_req, e_ireq);
            chk32("imem_addr", imem_addr, m_pc);
            chk32("pc", pc, m_pc);
            chk1("dmem_req", dmem_req, e_dreq);
            chk1("dmem_we", dmem_we, e_dreq && is_st);
            chk1("retire", retire, e_ret);
            chk1("rf_we", rf_we, e_ret && wr && (word[11:7] != 5'd0));
            chk1("trap", trap, 1'b0);
            if (c > iw) begin
                chk32("ir", ir, word);
                if (care_imm) chk32("imm", imm, e_imm);
                if (care_a)   chk1("alu_a_sel", alu_a_sel, e_a);
                if (care_b)   chk1("alu_b_sel", alu_b_sel, e_b);
                if (care_wb)  chk32("wb_sel", {30'd0, wb_sel}, {30'd0, e_wb});
            end
            if (retire && got_cycles < 0) got_cycles = c + 1;
        end

        if (will_trap) begin
            repeat (3) begin
                @(negedge clk);
                imem_ack = 1'b1;
                dmem_ack = 1'b1;
                #1;
                chk1("trap_flag", trap, 1'b1);
                chk1("trap_imem_req", imem_req, 1'b0);
                chk1("trap_dmem_req", dmem_req, 1'b0);
                chk1("trap_retire", retire, 1'b0);
                chk1("trap_rf_we", rf_we, 1'b0);
                chk32("trap_pc", pc, m_pc);
            end
            $display("instr pc=%h word=%h trapped", m_pc, word);
            do_reset();
        end else begin
            $display("instr pc=%h word=%h iw=%0d dw=%0d cycles=%0d next_pc=%h",
                     m_pc, word, iw, dw, got_cycles, e_next);
            m_pc = e_next;
        end
    endtask

    logic [6:0] rand_opc [11] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23,
                                  7'h63, 7'h6F, 7'h67, 7'h73, 7'h7F};
    logic [6:0] bad_opc [4]   = '{7'h00, 7'h0F, 7'h5B, 7'h7F};

    initial begin
        int          g;
        logic [31:0] w;

        do_reset();

        run_instr(32'h0050_0093, 0, 0, 1'b0, 32'h0, -1, g);      // addi x1,x0,5
        chk32("addi_cycles", g, 32'd4);
        pc_lit("addi_pc", 32'h4);

        run_instr(32'h0000_A283, 0, 2, 1'b0, 32'h0, -1, g);      // lw x5,0(x1), ack 2 late
        chk32("lw_cycles", g, 32'd7);
        pc_lit("lw_pc", 32'h8);

        run_instr(32'h0F80_00EF, 0, 0, 1'b0, 32'h0, -1, g);      // jal x1,+0xF8
        pc_lit("jal_pc", 32'h100);

        run_instr(32'hFE00_0CE3, 0, 0, 1'b1, 32'h0, -1, g);      // beq -8, taken
        chk32("beq_taken_cycles", g, 32'd3);
        pc_lit("beq_taken_pc", 32'hF8);

        run_instr(32'h0080_006F, 1, 0, 1'b0, 32'h0, -1, g);      // jal x0,+8
        pc_lit("jal_back_pc", 32'h100);

        run_instr(32'hFE00_0CE3, 0, 0, 1'b0, 32'h0, -1, g);      // beq -8, not taken
        pc_lit("beq_not_taken_pc", 32'h104);

        run_instr(32'h0001_00E7, 0, 0, 1'b0, 32'h205, -1, g);    // jalr x1,0(x2)
        chk32("jalr_cycles", g, 32'd4);
        pc_lit("jalr_pc", 32'h204);

        run_instr(32'h0000_007F, 0, 0, 1'b0, 32'h0, -1, g);      // unrecognised opcode
`ifdef CTRL_TRAP_EN
        chk32("illegal_cycles", g, 32'hFFFF_FFFF);
        pc_lit("illegal_pc", 32'h0);
`else
        chk32("illegal_cycles", g, 32'd3);
        pc_lit("illegal_pc", 32'h208);
`endif

        run_instr(32'h0001_00E7, 0, 0, 1'b0, 32'hFFFF_FFFC, -1, g);
        pc_lit("wrap_top_pc", 32'hFFFF_FFFC);
        run_instr(32'h0050_0093, 2, 0, 1'b0, 32'h0, -1, g);
        pc_lit("wrap_pc", 32'h0);

        run_instr(32'h0020_A023, 1, 1, 1'b0, 32'h0, -1, g);      // sw x2,0(x1)
        chk32("sw_cycles", g, 32'd6);
        pc_lit("sw_pc", 32'h4);

        run_instr(32'h0000_A283, 0, 5, 1'b0, 32'h0, 5, g);       // reset during MEM wait
        do_reset();
        pc_lit("after_abort_pc", 32'h0);

        for (int n = 0; n < 200; n++) begin
            int k;
            k = $urandom_range(0, 10);
            w = $urandom;
            w[6:0] = (k == 10) ? bad_opc[$urandom_range(0, 3)] : rand_opc[k];
            run_instr(w, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                      $urandom, -1, g);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
